sc_spi_sft: RTL and testbench



---
 rtl/sc_spi_pkg.sv | 14 +
 rtl/sc_spi_edge.sv | 23 ++
 rtl/sc_spi_sft.sv | 169 ++++++++++++++++
 tb/tb_sc_spi_sft.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_spi_pkg.sv
// Shared SPI package: byte/counter widths and the shift-engine state encoding.
package sc_spi_pkg;

    localparam int unsigned SPI_BYTE_W   = 8;
    localparam int unsigned SPI_BITCNT_W = 3;

    typedef logic [SPI_BYTE_W-1:0]   spi_byte_t;
    typedef logic [SPI_BITCNT_W-1:0] spi_bitcnt_t;

    localparam logic [1:0] SPI_SFT_IDLE  = 2'd0;
    localparam logic [1:0] SPI_SFT_SHIFT = 2'd1;
    localparam logic [1:0] SPI_SFT_DONE  = 2'd2;

endpackage

// File: rtl/sc_spi_edge.sv
// Registers the SPI clock and flags its leading (rising) and trailing (falling) edges.
module sc_spi_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic spiclk_i,
    output logic lead_c,
    output logic trail_c
);

    logic spiclk_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spiclk_q <= 1'b0;
        end else begin
            spiclk_q <= spiclk_i;
        end
    end

    assign lead_c  = spiclk_i & ~spiclk_q;
    assign trail_c = ~spiclk_i & spiclk_q;

endmodule

// File: rtl/sc_spi_sft.sv
// SPI byte shift engine: handshakes a byte in, shifts MOSI/samples MISO on SPICLK edges.
// Optional LSB-first mode via macro SC_SPI_SFT_LSBFIRST_EN (adds LSBFIRST input).
module sc_spi_sft
    import sc_spi_pkg::*;
(
    input  logic                  SRCCLK,
    input  logic                  SYSRSTB,
    input  logic                  CPHA,
    input  logic [SPI_BYTE_W-1:0] TXDATA,
    input  logic                  TXVALID,
    output logic                  TXREADY,
    input  logic                  ABORT,
    output logic [SPI_BYTE_W-1:0] RXDATA,
    output logic                  RXVALID,
    output logic                  BUSY,
    output logic                  CLK_ENABLE,
    input  logic                  SPICLK,
    output logic                  MOSI,
    input  logic                  MISO
`ifdef SC_SPI_SFT_LSBFIRST_EN
    ,
    input  logic                  LSBFIRST
`endif
);

    logic [1:0]  state_q, state_d;
    spi_byte_t   tx_sr_q, tx_sr_d;
    spi_byte_t   rx_sr_q, rx_sr_d;
    spi_bitcnt_t bit_cnt_q, bit_cnt_d;
    spi_byte_t   rxdata_q, rxdata_d;
    logic        clk_en_q, clk_en_d;
    logic        busy_q, busy_d;
    logic        mosi_q, mosi_d;
    logic        rxvalid_q, rxvalid_d;

    logic        lead_c, trail_c;
    logic        lsb_c;
    logic        tx_out_bit_c, tx_next_bit_c, tx_first_bit_c;
    spi_byte_t   tx_shift_c, rx_shift_c;
    logic        last_bit_c;

    sc_spi_edge u_edge (
        .clk      (SRCCLK),
        .rst_n    (SYSRSTB),
        .spiclk_i (SPICLK),
        .lead_c   (lead_c),
        .trail_c  (trail_c)
    );

`ifdef SC_SPI_SFT_LSBFIRST_EN
    assign lsb_c = LSBFIRST;
`else
    assign lsb_c = 1'b0;
`endif

    // Bit ordering: MSB-first shifts left, LSB-first shifts right.
    assign tx_out_bit_c   = lsb_c ? tx_sr_q[0] : tx_sr_q[SPI_BYTE_W-1];
    assign tx_next_bit_c  = lsb_c ? tx_sr_q[1] : tx_sr_q[SPI_BYTE_W-2];
    assign tx_first_bit_c = lsb_c ? TXDATA[0]  : TXDATA[SPI_BYTE_W-1];
    assign tx_shift_c     = lsb_c ? {1'b0, tx_sr_q[SPI_BYTE_W-1:1]}
                                  : {tx_sr_q[SPI_BYTE_W-2:0], 1'b0};
    assign rx_shift_c     = lsb_c ? {MISO, rx_sr_q[SPI_BYTE_W-1:1]}
                                  : {rx_sr_q[SPI_BYTE_W-2:0], MISO};
    assign last_bit_c     = (bit_cnt_q == SPI_BITCNT_W'(SPI_BYTE_W - 1));

    always_comb begin
        state_d   = state_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        bit_cnt_d = bit_cnt_q;
        rxdata_d  = rxdata_q;
        clk_en_d  = clk_en_q;
        busy_d    = busy_q;
        mosi_d    = mosi_q;
        rxvalid_d = 1'b0;

        case (state_q)
            SPI_SFT_IDLE: begin
                if (TXVALID) begin
                    tx_sr_d   = TXDATA;
                    bit_cnt_d = '0;
                    clk_en_d  = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = SPI_SFT_SHIFT;
                    if (!CPHA) begin
                        mosi_d = tx_first_bit_c;
                    end
                end
            end
            SPI_SFT_SHIFT: begin
                // Abort outranks every edge, including the final trail.
                if (ABORT) begin
                    clk_en_d = 1'b0;
                    busy_d   = 1'b0;
                    state_d  = SPI_SFT_IDLE;
                end else if (!CPHA) begin
                    if (lead_c) begin
                        rx_sr_d = rx_shift_c;
                    end
                    if (trail_c) begin
                        if (last_bit_c) begin
                            clk_en_d = 1'b0;
                            state_d  = SPI_SFT_DONE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + SPI_BITCNT_W'(1);
                            tx_sr_d   = tx_shift_c;
                            mosi_d    = tx_next_bit_c;
                        end
                    end
                end else begin
                    if (lead_c) begin
                        mosi_d  = tx_out_bit_c;
                        tx_sr_d = tx_shift_c;
                    end
                    if (trail_c) begin
                        rx_sr_d = rx_shift_c;
                        if (last_bit_c) begin
                            clk_en_d = 1'b0;
                            state_d  = SPI_SFT_DONE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + SPI_BITCNT_W'(1);
                        end
                    end
                end
            end
            SPI_SFT_DONE: begin
                rxdata_d  = rx_sr_q;
                rxvalid_d = 1'b1;
                busy_d    = 1'b0;
                state_d   = SPI_SFT_IDLE;
            end
            default: begin
                state_d = SPI_SFT_IDLE;
            end
        endcase
    end

    always_ff @(posedge SRCCLK) begin
        if (!SYSRSTB) begin
            state_q   <= SPI_SFT_IDLE;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            bit_cnt_q <= '0;
            rxdata_q  <= '0;
            clk_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            mosi_q    <= 1'b0;
            rxvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            bit_cnt_q <= bit_cnt_d;
            rxdata_q  <= rxdata_d;
            clk_en_q  <= clk_en_d;
            busy_q    <= busy_d;
            mosi_q    <= mosi_d;
            rxvalid_q <= rxvalid_d;
        end
    end

    assign TXREADY    = (state_q == SPI_SFT_IDLE);
    assign RXDATA     = rxdata_q;
    assign RXVALID    = rxvalid_q;
    assign BUSY       = busy_q;
    assign CLK_ENABLE = clk_en_q;
    assign MOSI       = mosi_q;

endmodule

// File: tb/tb_sc_spi_sft.sv
// Bench for sc_spi_sft: clock-generator stand-in, SPI slave model and randomized transfers.
module tb_sc_spi_sft;

    logic       SRCCLK = 1'b0;
    logic       SYSRSTB;
    logic       CPHA;
    logic [7:0] TXDATA;
    logic       TXVALID;
    logic       TXREADY;
    logic       ABORT;
    logic [7:0] RXDATA;
    logic       RXVALID;
    logic       BUSY;
    logic       CLK_ENABLE;
    logic       SPICLK;
    logic       MOSI;
    logic       MISO;
`ifdef SC_SPI_SFT_LSBFIRST_EN
    logic       LSBFIRST;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    // Clock generator stand-in and slave state
    int         half_v = 2;
    int         gcnt;
    logic       loopback = 1'b0;
    logic       miso_slv = 1'b0;
    logic       cpha_v = 1'b0;
    logic       lsb_v = 1'b0;
    logic [7:0] slv_tx, slv_rx;
    logic       prev_sclk = 1'b0, prev_ld = 1'b0, mosi_prev = 1'b0, en_prev = 1'b0;
    logic       first_bit;
    logic [7:0] rxv_data;
    int cyc = 0, nlead, ntrail, nsamp, mosi_bad, rxv_cnt, rxv_cyc, last_trail_cyc;
    int first_lead_cyc, low_run = 0, last_low_run = 0;

    sc_spi_sft dut (
        .SRCCLK     (SRCCLK),
        .SYSRSTB    (SYSRSTB),
        .CPHA       (CPHA),
        .TXDATA     (TXDATA),
        .TXVALID    (TXVALID),
        .TXREADY    (TXREADY),
        .ABORT      (ABORT),
        .RXDATA     (RXDATA),
        .RXVALID    (RXVALID),
        .BUSY       (BUSY),
        .CLK_ENABLE (CLK_ENABLE),
        .SPICLK     (SPICLK),
        .MOSI       (MOSI),
        .MISO       (MISO)
`ifdef SC_SPI_SFT_LSBFIRST_EN
        ,
        .LSBFIRST   (LSBFIRST)
`endif
    );

    always #5 SRCCLK = ~SRCCLK;

    // SPICLK toggles every half_v cycles while enabled, first rise one cycle after enable.
    always @(posedge SRCCLK) begin
        if (!SYSRSTB || !CLK_ENABLE) begin
            SPICLK <= 1'b0;
            gcnt   <= 0;
        end else if (gcnt == 0) begin
            SPICLK <= ~SPICLK;
            gcnt   <= half_v - 1;
        end else begin
            gcnt <= gcnt - 1;
        end
    end

    assign MISO = loopback ? MOSI : miso_slv;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One cycle: advance to the negedge, then play the slave and record observations.
    task automatic step();
        logic ld, tr;
        @(negedge SRCCLK);
        cyc++;
        ld = SPICLK & ~prev_sclk;
        tr = ~SPICLK & prev_sclk;
        prev_sclk = SPICLK;
        if (cpha_v && BUSY && (MOSI !== mosi_prev) && !prev_ld) mosi_bad++;
        mosi_prev = MOSI;
        prev_ld   = ld;
        if (CLK_ENABLE && ld) begin
            if (nlead == 0) first_lead_cyc = cyc;
            nlead++;
            if (cpha_v) begin
                miso_slv = slv_tx[7];
                slv_tx   = slv_tx << 1;
            end else begin
                if (nsamp == 0) first_bit = MOSI;
                nsamp++;
                slv_rx = {slv_rx[6:0], MOSI};
            end
        end
        if (CLK_ENABLE && tr) begin
            ntrail++;
            last_trail_cyc = cyc;
            if (cpha_v) begin
                if (nsamp == 0) first_bit = MOSI;
                nsamp++;
                slv_rx = {slv_rx[6:0], MOSI};
            end else begin
                slv_tx   = slv_tx << 1;
                miso_slv = slv_tx[7];
            end
        end
        if (RXVALID) begin
            rxv_cnt++;
            rxv_cyc  = cyc;
            rxv_data = RXDATA;
        end
        if (CLK_ENABLE && !en_prev) last_low_run = low_run;
        low_run = CLK_ENABLE ? 0 : low_run + 1;
        en_prev = CLK_ENABLE;
    endtask

    task automatic xfer(input logic [7:0] tx, input logic [7:0] m, input logic cpha,
                        input logic lsb, input logic loop, input int abort_at, input string tag);
        logic [7:0] rx_before, exp_rx, slave_got;
        int n, acc_cyc;
        cpha_v = cpha; lsb_v = lsb; loopback = loop; CPHA = cpha;
`ifdef SC_SPI_SFT_LSBFIRST_EN
        LSBFIRST = lsb;
`endif
        slv_tx   = lsb ? rev8(m) : m;
        slv_rx   = 8'h00;
        miso_slv = cpha ? 1'b0 : slv_tx[7];
        nlead = 0; ntrail = 0; nsamp = 0; mosi_bad = 0; rxv_cnt = 0;
        rx_before = RXDATA;
        exp_rx    = loop ? tx : m;
        check({tag, "_rdy"}, 32'(TXREADY), 32'd1);
        TXDATA  = tx;
        TXVALID = 1'b1;
        step();
        acc_cyc = cyc;
        TXVALID = 1'b0;
        check({tag, "_acc"}, {30'd0, BUSY, CLK_ENABLE}, 32'd3);
        n = 0;
        while (rxv_cnt == 0 && n < 2000 && !(abort_at > 0 && ntrail >= abort_at)) begin
            step();
            n++;
        end
        if (abort_at > 0) begin
            check({tag, "_abtrail"}, 32'(ntrail), 32'(abort_at));
            ABORT = 1'b1;
            step();
            ABORT = 1'b0;
            check({tag, "_abstate"}, {29'd0, CLK_ENABLE, BUSY, TXREADY}, 32'd1);
            repeat (4) step();
            check({tag, "_abnorxv"}, 32'(rxv_cnt), 32'd0);
            check({tag, "_abrxdata"}, 32'(RXDATA), 32'(rx_before));
        end else begin
            step();
            step();
            slave_got = lsb ? rev8(slv_rx) : slv_rx;
            check({tag, "_rxvcnt"}, 32'(rxv_cnt), 32'd1);
            check({tag, "_rxdata"}, 32'(rxv_data), 32'(exp_rx));
            check({tag, "_mosi"}, 32'(slave_got), 32'(tx));
            check({tag, "_edges"}, 32'((nlead << 8) | ntrail), 32'h0808);
            check({tag, "_trl2rxv"}, 32'(rxv_cyc - last_trail_cyc), 32'd2);
            check({tag, "_lead1"}, 32'(first_lead_cyc - acc_cyc), 32'd1);
            check({tag, "_mosilead"}, 32'(mosi_bad), 32'd0);
            check({tag, "_idle"}, {30'd0, BUSY, TXREADY}, 32'd1);
        end
        repeat (2) step();
    endtask

    initial begin
        int n, ab;
        logic c_r, l_r, lsb_r;
        SYSRSTB = 1'b0; CPHA = 1'b0; TXDATA = 8'h00; TXVALID = 1'b0; ABORT = 1'b0;
`ifdef SC_SPI_SFT_LSBFIRST_EN
        LSBFIRST = 1'b0;
`endif
        repeat (3) step();
        check("rst_outs", {27'd0, CLK_ENABLE, MOSI, RXVALID, BUSY, 1'b0}, 32'd0);
        check("rst_rxdata", 32'(RXDATA), 32'd0);
        SYSRSTB = 1'b1;
        step();
        check("rst_txready", 32'(TXREADY), 32'd1);
        repeat (2) step();

        half_v = 2;
        xfer(8'hA5, 8'h00, 1'b0, 1'b0, 1'b1, 0, "lb_cpha0");
        xfer(8'h3C, 8'hC3, 1'b1, 1'b0, 1'b0, 0, "cpha1");

        // Back-to-back with TXVALID held high across two bytes
        cpha_v = 1'b0; lsb_v = 1'b0; loopback = 1'b1; CPHA = 1'b0; rxv_cnt = 0;
        nlead = 0; ntrail = 0; nsamp = 0;
        TXDATA = 8'h01; TXVALID = 1'b1;
        step();
        TXDATA = 8'h80;
        n = 0;
        while (rxv_cnt == 0 && n < 2000) begin step(); n++; end
        check("b2b_rx1", 32'(rxv_data), 32'h01);
        check("b2b_rdy", 32'(TXREADY), 32'd1);
        step();
        TXVALID = 1'b0;
        check("b2b_acc", 32'(BUSY), 32'd1);
        n = 0;
        while (rxv_cnt < 2 && n < 2000) begin step(); n++; end
        check("b2b_rx2", 32'(rxv_data), 32'h80);
        check("b2b_gap", 32'(last_low_run >= 2), 32'd1);
        repeat (3) step();

        xfer(8'h5A, 8'h96, 1'b0, 1'b0, 1'b0, 3, "abort3");
        xfer(8'hE7, 8'h18, 1'b1, 1'b0, 1'b0, 8, "abort8");

`ifdef SC_SPI_SFT_LSBFIRST_EN
        xfer(8'h01, 8'h00, 1'b0, 1'b1, 1'b1, 0, "lsb");
        check("lsb_first", 32'(first_bit), 32'd1);
`endif

        for (int t = 0; t < 24; t++) begin
            half_v = int'($urandom_range(1, 4));
            c_r    = 1'($urandom_range(0, 1));
            l_r    = 1'($urandom_range(0, 1));
            lsb_r  = 1'b0;
`ifdef SC_SPI_SFT_LSBFIRST_EN
            lsb_r  = 1'($urandom_range(0, 1));
`endif
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 8)) : 0;
            xfer(8'($urandom), 8'($urandom), c_r, lsb_r, l_r, ab, "rnd");
            step();
        end

        // Reset in the middle of a transfer with MOSI driven high
        half_v = 2;
        xfer(8'h6B, 8'h9D, 1'b0, 1'b0, 1'b0, 0, "pre_rst");
        cpha_v = 1'b0; lsb_v = 1'b0; loopback = 1'b1; CPHA = 1'b0;
        TXDATA = 8'hFF; TXVALID = 1'b1;
        step();
        TXVALID = 1'b0;
        repeat (5) step();
        check("mid_busy", {30'd0, BUSY, MOSI}, 32'd3);
        SYSRSTB = 1'b0;
        step();
        check("mid_rst_outs", {27'd0, CLK_ENABLE, MOSI, RXVALID, BUSY, TXREADY}, 32'd1);
        check("mid_rst_rxdata", 32'(RXDATA), 32'd0);
        SYSRSTB = 1'b1;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
